// File: rtl/spi_cfg_slave_pkg.sv
// Shared frame geometry and FSM state encoding for the SPI configuration slave.
package spi_cfg_slave_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;
    localparam int CNT_BITS   = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing one asynchronous bit into the clk domain.
// Latency: 2 clk cycles. No backpressure; free-running sampler.
// Reset value is a parameter so idle-high lines do not glitch at reset release.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 slave writing 16-bit {wr, addr, data} frames into a config register file.
// Latency: write strobe 1 clk after the 16th synced sample (plus 2-flop sync delay).
// No backpressure: SPI master is free-running; frames arriving too fast are not stalled.
module spi_cfg_slave
    import spi_cfg_slave_pkg::*;
#(
    parameter int                   NUM_REGS  = 8,
    parameter logic [DATA_BITS-1:0] RESET_VAL = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    input  logic                          spi_nss,
    output logic [NUM_REGS*DATA_BITS-1:0] cfg_regs,
    output logic                          wr_strobe,
    output logic [ADDR_BITS-1:0]          wr_addr,
    output logic [DATA_BITS-1:0]          wr_data,
    output logic                          frame_err
);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(FRAME_BITS - 1);

    logic sclk_s, mosi_s, nss_s;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi_clk),  .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_nss  (.clk(clk), .rst(rst), .d(spi_nss),  .q(nss_s));

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic                  nss_prev_q, nss_prev_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic                  frame_err_q, frame_err_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]  wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0]  regs_q [NUM_REGS];
    logic [DATA_BITS-1:0]  regs_d [NUM_REGS];

    logic   sample, nss_fall;
    frame_t frame_nxt;

    // An edge coinciding with nss rising is dropped because nss_s is already high.
    assign sample    = sclk_s && !sclk_prev_q && !nss_s;
    assign nss_fall  = nss_prev_q && !nss_s;
    assign frame_nxt = frame_t'({shift_q[FRAME_BITS-2:0], mosi_s});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sclk_prev_d = sclk_s;
        nss_prev_d  = nss_s;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (nss_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sample) begin
                    shift_d = frame_nxt;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        if (frame_nxt.wr) begin
                            if (int'(frame_nxt.addr) < NUM_REGS) begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = frame_nxt.addr;
                                wr_data_d   = frame_nxt.data;
                            end else begin
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (nss_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_strobe_d && (wr_addr_d == ADDR_BITS'(k))) begin
                regs_d[k] = wr_data_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            sclk_prev_q <= 1'b0;
            nss_prev_q  <= 1'b1;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sclk_prev_q <= sclk_prev_d;
            nss_prev_q  <= nss_prev_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[g*DATA_BITS +: DATA_BITS] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
endmodule

// File: tb/tb_spi_cfg_slave.sv
// Directed frame table plus hand sequences for reset-mid-frame, against spi_cfg_slave.
module tb_spi_cfg_slave;
    localparam int HALF = 5;

    logic        clk;
    logic        rst;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_nss;
    logic [63:0] cfg_regs;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;

    spi_cfg_slave #(.NUM_REGS(8), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_nss  (spi_nss),
        .cfg_regs (cfg_regs),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int str_cnt  = 0;
    int err_cnt  = 0;
    int bad_cnt  = 0;
    logic prev_str = 1'b0;
    logic prev_err = 1'b0;

    // Pulse monitor: counts strobes/errors and flags overlap or multi-cycle pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_strobe) str_cnt++;
            if (frame_err) err_cnt++;
            if (wr_strobe && frame_err) bad_cnt++;
            if (wr_strobe && prev_str) bad_cnt++;
            if (frame_err && prev_err) bad_cnt++;
        end
        prev_str = wr_strobe;
        prev_err = frame_err;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic clock_bits(input logic [15:0] f, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = f[15-b];
            repeat (HALF) @(posedge clk);
            spi_clk = 1'b1;
            repeat (HALF) @(posedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] f, input int nbits, input int extra);
        logic [15:0] junk;
        spi_nss = 1'b0;
        repeat (6) @(posedge clk);
        clock_bits(f, nbits);
        junk = 16'($urandom);
        clock_bits(junk, extra);
        repeat (HALF) @(posedge clk);
        spi_nss  = 1'b1;
        spi_mosi = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    typedef struct {
        string       name;
        logic [15:0] frame;
        int          nbits;
        int          extra;
        int          exp_str;
        int          exp_err;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_data;
        logic [63:0] exp_regs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s0, e0;

        vecs[0] = '{"wr_r3_05",    16'h8305, 16, 0, 1, 0, 7'd3, 8'h05, 64'h0000_0000_0500_0000};
        vecs[1] = '{"noop_0312",   16'h0312, 16, 0, 0, 0, 7'd3, 8'h05, 64'h0000_0000_0500_0000};
        vecs[2] = '{"oor_8AFF",    16'h8AFF, 16, 0, 0, 1, 7'd3, 8'h05, 64'h0000_0000_0500_0000};
        vecs[3] = '{"abort9_81AA", 16'h81AA,  9, 0, 0, 1, 7'd3, 8'h05, 64'h0000_0000_0500_0000};
        vecs[4] = '{"wr_r1_AA",    16'h81AA, 16, 0, 1, 0, 7'd1, 8'hAA, 64'h0000_0000_0500_AA00};
        vecs[5] = '{"extra_8077",  16'h8077, 16, 8, 1, 0, 7'd0, 8'h77, 64'h0000_0000_0500_AA77};
        vecs[6] = '{"wr_r7_C3",    16'h87C3, 16, 0, 1, 0, 7'd7, 8'hC3, 64'hC300_0000_0500_AA77};
        vecs[7] = '{"oor_addr8",   16'h8811, 16, 0, 0, 1, 7'd7, 8'hC3, 64'hC300_0000_0500_AA77};

        rst      = 1'b0;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_nss  = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_regs",      cfg_regs, 64'h0);
        chk("rst_wr_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        chk("rst_wr_addr",   64'(wr_addr), 64'h0);
        chk("rst_wr_data",   64'(wr_data), 64'h0);
        rst = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            s0 = str_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].frame, vecs[i].nbits, vecs[i].extra);
            @(negedge clk);
            chk({vecs[i].name, "_strobes"}, 64'(str_cnt - s0), 64'(vecs[i].exp_str));
            chk({vecs[i].name, "_errs"},    64'(err_cnt - e0), 64'(vecs[i].exp_err));
            chk({vecs[i].name, "_regs"},    cfg_regs, vecs[i].exp_regs);
            chk({vecs[i].name, "_addr"},    64'(wr_addr), 64'(vecs[i].exp_addr));
            chk({vecs[i].name, "_data"},    64'(wr_data), 64'(vecs[i].exp_data));
        end

        // Reset in the middle of a frame discards the partial frame.
        s0 = str_cnt;
        e0 = err_cnt;
        spi_nss = 1'b0;
        repeat (6) @(posedge clk);
        clock_bits(16'h8242, 8);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_regs_in_reset", cfg_regs, 64'h0);
        chk("midrst_addr_in_reset", 64'(wr_addr), 64'h0);
        spi_nss = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("midrst_strobes", 64'(str_cnt - s0), 64'h0);
        chk("midrst_errs",    64'(err_cnt - e0), 64'h0);
        chk("midrst_regs",    cfg_regs, 64'h0);

        s0 = str_cnt;
        e0 = err_cnt;
        send_frame(16'h8242, 16, 0);
        @(negedge clk);
        chk("post_rst_strobes", 64'(str_cnt - s0), 64'h1);
        chk("post_rst_errs",    64'(err_cnt - e0), 64'h0);
        chk("post_rst_addr",    64'(wr_addr), 64'h2);
        chk("post_rst_data",    64'(wr_data), 64'h42);
        chk("post_rst_regs",    cfg_regs, 64'h0000_0000_0042_0000);

        chk("pulse_shape_violations", 64'(bad_cnt), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/spi_cfg_slave.md
SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 8-bit configuration registers (1..128).
REQ-002 Parameter RESET_VAL, default 0, 8-bit reset value of every configuration register.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 spi_clk  input  1  SPI serial clock, mode 0, asynchronous to clk, at most clk/8.
REQ-006 spi_mosi  input  1  SPI data in, MSB first, sampled on spi_clk rising edge.
REQ-007 spi_nss  input  1  SPI chip select, active-low, frames one transaction.
REQ-008 cfg_regs  output  NUM_REGS*8  flattened register file; register k at bits [8k+7:8k].
REQ-009 wr_strobe  output  1  one-cycle pulse when a register is written.
REQ-010 wr_addr  output  7  address of the last write; valid while wr_strobe is high.
REQ-011 wr_data  output  8  data of the last write; valid while wr_strobe is high.
REQ-012 frame_err  output  1  one-cycle pulse on an aborted frame or an out-of-range address.

Function
REQ-013 spi_clk, spi_mosi and spi_nss shall each pass through a 2-flop synchronizer into clk before use.
REQ-014 A bit shall be sampled when synced spi_clk rises (previous 0, current 1) while synced spi_nss is 0; the sampled value is synced spi_mosi.
REQ-015 A frame is 16 bits, MSB first:
- bit 15: write flag, 1 = write, 0 = no-op.
- bits 14:8: address.
- bits 7:0: data.
REQ-016 The state machine shall have exactly three states:
- IDLE: synced nss falling -> SHIFT, with bit counter cleared.
- SHIFT: counter increments 0..15 per sampled bit; 16th bit -> DONE; synced nss high before the 16th bit -> IDLE with a frame_err pulse.
- DONE: additional sampled bits are ignored; synced nss high -> IDLE.
REQ-017 On the cycle that the 16th bit is sampled, the frame shall be evaluated; if write flag = 1 and address < NUM_REGS, the register shall update and wr_strobe/wr_addr/wr_data shall assert on the next clk edge (1-cycle latency from the 16th sampled edge).
REQ-018 Write flag 1 with address >= NUM_REGS shall leave cfg_regs unchanged, give no wr_strobe, and pulse frame_err in the same cycle wr_strobe would have fired.
REQ-019 Write flag 0 shall produce no write, no wr_strobe and no frame_err.
REQ-020 A synced spi_clk rising edge in the same cycle as synced nss going high shall not be sampled; if the frame is incomplete it aborts per REQ-016.
REQ-021 wr_strobe and frame_err shall never be high in the same cycle, and neither shall be high for more than one cycle per frame.
REQ-022 Back-to-back frames with nss high for at least 3 clk cycles between them shall each be handled independently.
REQ-023 wr_addr and wr_data shall hold their last written values between strobes.

Reset
REQ-024 While rst = 0:
- every cfg_regs byte shall equal RESET_VAL;
- wr_strobe and frame_err = 0; wr_addr and wr_data = 0;
- state = IDLE, bit counter = 0, shift register = 0;
- synchronizer flops: spi_nss flops = 1, other flops = 0.
REQ-025 Reset asserted mid-frame shall discard the partial frame; after release the block waits in IDLE for a fresh nss falling edge.

Structure
REQ-026 A shared package shall hold FRAME_BITS = 16, ADDR_BITS = 7, DATA_BITS = 8 and the state enumeration (IDLE, SHIFT, DONE).
REQ-027 The 2-flop synchronizer shall be a sub-module named sync_2ff, with a reset-value parameter, instantiated three times.
REQ-028 cfg_regs feeds the synthesizer core's configuration inputs directly; no further buffering.

Verification
REQ-029 Reset release, then frame 0x8305 -> one wr_strobe with wr_addr = 3 and wr_data = 0x05; cfg_regs[31:24] = 0x05; all other bytes = 0.
REQ-030 Frame 0x0312 (write flag 0) -> no wr_strobe, no frame_err, cfg_regs unchanged.
REQ-031 Frame 0x8AFF (address 10 >= 8) -> a single frame_err pulse, no wr_strobe, cfg_regs unchanged.
REQ-032 nss raised after 9 bits of 0x81AA -> frame_err pulse; the next full frame 0x81AA writes register 1 = 0xAA.
REQ-033 Frame 0x8077 followed by 8 extra spi_clk pulses before nss high -> exactly one write (register 0 = 0x77); extra bits ignored.
REQ-034 rst pulsed low after 8 bits of 0x8242 -> no write; all registers = RESET_VAL; the next full frame 0x8242 writes register 2 = 0x42.
